// File: rtl/tb4004_pkg.sv
// Shared TB4004 constants: command encoding, cycle phases, stack depths.
package tb4004_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_JUMP = 2'b01,
    CMD_CALL = 2'b10,
    CMD_RET  = 2'b11
  } cmd_e;

  localparam int unsigned CYC_W = 3;

  localparam logic [CYC_W-1:0] CYC_INC  = 3'd2;
  localparam logic [CYC_W-1:0] CYC_EXEC = 3'd7;

  localparam int unsigned STK_DEPTH_4004 = 3;
  localparam int unsigned STK_DEPTH_4040 = 7;

endpackage

// File: rtl/addr_stack.sv
// Circular return-address LIFO with push/pop strobes and overflow/underflow pulses.
module addr_stack #(
  parameter  int unsigned ADDR_W = 12,
  parameter  int unsigned DEPTH  = 3,
  localparam int unsigned SP_W   = $clog2(DEPTH),
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_push_data,
  output logic [ADDR_W-1:0] o_pop_data_c,
  output logic [SP_W-1:0]   o_sp,
  output logic [CNT_W-1:0]  o_cnt,
  output logic              o_ovf,
  output logic              o_unf
);

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [SP_W-1:0]   r_sp;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;
  logic              r_unf;
  logic [SP_W-1:0]   w_sp_inc;
  logic [SP_W-1:0]   w_sp_dec;
  logic              w_full;
  logic              w_empty;

  // Pointer wrap arithmetic and occupancy status.
  always_comb begin
    w_sp_inc = (r_sp == SP_W'(DEPTH - 1)) ? '0 : r_sp + SP_W'(1);
    w_sp_dec = (r_sp == '0) ? SP_W'(DEPTH - 1) : r_sp - SP_W'(1);
    w_full   = (r_cnt == CNT_W'(DEPTH));
    w_empty  = (r_cnt == '0);
  end

  // Entry below the write pointer; a pop always reads it, even when stale.
  assign o_pop_data_c = r_mem[w_sp_dec];

  // Storage array: written only by push, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (i_push) begin
      r_mem[r_sp] <= i_push_data;
    end
  end

  // Pointer, count and single-clock ovf/unf pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= i_push & w_full;
      r_unf <= i_pop & w_empty;
      if (i_push) begin
        r_sp <= w_sp_inc;
        if (!w_full) r_cnt <= r_cnt + CNT_W'(1);
      end else if (i_pop) begin
        r_sp <= w_sp_dec;
        if (!w_empty) r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign o_sp  = r_sp;
  assign o_cnt = r_cnt;
  assign o_ovf = r_ovf;
  assign o_unf = r_unf;

endmodule

// File: rtl/pc_call_stack.sv
// TB4004 program-address unit: PC register, cycle qualification, next-PC mux.
module pc_call_stack
  import tb4004_pkg::*;
#(
  parameter  int unsigned      ADDR_W     = 12,
  parameter  int unsigned      DEPTH      = STK_DEPTH_4004,
  parameter  logic [CYC_W-1:0] INC_CYCLE  = CYC_INC,
  parameter  logic [CYC_W-1:0] EXEC_CYCLE = CYC_EXEC,
  localparam int unsigned      SP_W       = $clog2(DEPTH),
  localparam int unsigned      CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CYC_W-1:0]  cycle,
  input  logic              pc_inc,
  input  logic [1:0]        cmd,
  input  logic [ADDR_W-1:0] pc_new,
  output logic [ADDR_W-1:0] pc_addr,
  output logic [SP_W-1:0]   sp,
  output logic [CNT_W-1:0]  stk_cnt,
  output logic              stk_ovf,
  output logic              stk_unf
);

  // Increment and command must never share an edge; depth must be sane.
  if (INC_CYCLE == EXEC_CYCLE) begin : g_bad_cycles
    $error("pc_call_stack: INC_CYCLE must differ from EXEC_CYCLE");
  end
  if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
    $error("pc_call_stack: DEPTH must be in 2..16");
  end

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_pop_data;
  logic              w_inc_en;
  logic              w_exec;
  logic              w_push;
  logic              w_pop;
  cmd_e              w_cmd;

  // Qualify increment and command by the current phase.
  always_comb begin
    w_cmd    = cmd_e'(cmd);
    w_inc_en = (cycle == INC_CYCLE) & pc_inc;
    w_exec   = (cycle == EXEC_CYCLE);
    w_push   = w_exec & (w_cmd == CMD_CALL);
    w_pop    = w_exec & (w_cmd == CMD_RET);
  end

  // Next-PC select: hold, increment, jump/call target or popped return address.
  always_comb begin
    w_pc_nxt = r_pc;
    if (w_inc_en) begin
      w_pc_nxt = r_pc + ADDR_W'(1);
    end else if (w_exec) begin
      case (w_cmd)
        CMD_JUMP: w_pc_nxt = pc_new;
        CMD_CALL: w_pc_nxt = pc_new;
        CMD_RET:  w_pc_nxt = w_pop_data;
        default:  w_pc_nxt = r_pc;
      endcase
    end
  end

  // Program counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pc <= '0;
    else        r_pc <= w_pc_nxt;
  end

  addr_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_addr_stack (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_push_data  (r_pc),
    .o_pop_data_c (w_pop_data),
    .o_sp         (sp),
    .o_cnt        (stk_cnt),
    .o_ovf        (stk_ovf),
    .o_unf        (stk_unf)
  );

  assign pc_addr = r_pc;

endmodule

// File: tb/tb_pc_call_stack.sv
// Directed scoreboard bench for pc_call_stack in 4004 (depth 3) and 4040 (depth 7) modes.
module tb_pc_call_stack;

  localparam logic [1:0] C_NOP  = 2'b00;
  localparam logic [1:0] C_JUMP = 2'b01;
  localparam logic [1:0] C_CALL = 2'b10;
  localparam logic [1:0] C_RET  = 2'b11;

  logic        clk;
  logic        rst_n;
  logic [2:0]  cycle;
  logic        pc_inc;
  logic [1:0]  cmd;
  logic [11:0] pc_new;

  logic [11:0] pc3, pc7;
  logic [1:0]  sp3, cnt3;
  logic [2:0]  sp7, cnt7;
  logic        ovf3, unf3, ovf7, unf7;

  pc_call_stack #(.ADDR_W(12), .DEPTH(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .cycle(cycle), .pc_inc(pc_inc), .cmd(cmd),
    .pc_new(pc_new), .pc_addr(pc3), .sp(sp3), .stk_cnt(cnt3),
    .stk_ovf(ovf3), .stk_unf(unf3)
  );

  pc_call_stack #(.ADDR_W(12), .DEPTH(7)) u_d7 (
    .clk(clk), .rst_n(rst_n), .cycle(cycle), .pc_inc(pc_inc), .cmd(cmd),
    .pc_new(pc_new), .pc_addr(pc7), .sp(sp7), .stk_cnt(cnt7),
    .stk_ovf(ovf7), .stk_unf(unf7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] pc [2];
    int          sp [2];
    int          cnt[2];
    logic        ovf[2];
    logic        unf[2];
  } exp_t;

  exp_t        sb[$];
  int          total;
  int          bad;
  int          ovf_seen3;
  int          ovf_seen7;

  int          dep[2] = '{3, 7};
  logic [11:0] m_stk[2][16];
  logic [11:0] m_pc [2];
  int          m_sp [2];
  int          m_cnt[2];
  logic        m_ovf[2];
  logic        m_unf[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = '0; m_sp[i] = 0; m_cnt[i] = 0; m_ovf[i] = 1'b0; m_unf[i] = 1'b0;
      for (int j = 0; j < 16; j++) m_stk[i][j] = '0;
    end
  endtask

  // Predict one edge, queue the expectation, then pop and compare after the edge.
  task automatic tick();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      m_ovf[i] = 1'b0;
      m_unf[i] = 1'b0;
      if (!rst_n) begin
        m_pc[i] = '0; m_sp[i] = 0; m_cnt[i] = 0;
        for (int j = 0; j < 16; j++) m_stk[i][j] = '0;
      end else begin
        if (cycle == 3'd2 && pc_inc) m_pc[i] = m_pc[i] + 12'd1;
        if (cycle == 3'd7) begin
          case (cmd)
            C_JUMP: m_pc[i] = pc_new;
            C_CALL: begin
              m_stk[i][m_sp[i]] = m_pc[i];
              m_pc[i] = pc_new;
              m_sp[i] = (m_sp[i] + 1) % dep[i];
              if (m_cnt[i] == dep[i]) m_ovf[i] = 1'b1;
              else m_cnt[i]++;
            end
            C_RET: begin
              m_sp[i] = (m_sp[i] + dep[i] - 1) % dep[i];
              m_pc[i] = m_stk[i][m_sp[i]];
              if (m_cnt[i] == 0) m_unf[i] = 1'b1;
              else m_cnt[i]--;
            end
            default: ;
          endcase
        end
      end
      e.pc[i] = m_pc[i]; e.sp[i] = m_sp[i]; e.cnt[i] = m_cnt[i];
      e.ovf[i] = m_ovf[i]; e.unf[i] = m_unf[i];
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("d3.pc",  32'(pc3),  32'(e.pc[0]));
    chk("d3.sp",  32'(sp3),  32'(e.sp[0]));
    chk("d3.cnt", 32'(cnt3), 32'(e.cnt[0]));
    chk("d3.ovf", 32'(ovf3), 32'(e.ovf[0]));
    chk("d3.unf", 32'(unf3), 32'(e.unf[0]));
    chk("d7.pc",  32'(pc7),  32'(e.pc[1]));
    chk("d7.sp",  32'(sp7),  32'(e.sp[1]));
    chk("d7.cnt", 32'(cnt7), 32'(e.cnt[1]));
    chk("d7.ovf", 32'(ovf7), 32'(e.ovf[1]));
    chk("d7.unf", 32'(unf7), 32'(e.unf[1]));
    ovf_seen3 += int'(ovf3);
    ovf_seen7 += int'(ovf7);
  endtask

  // One 8-clock frame with pc_inc and cmd held across every phase.
  task automatic frame(input logic inc, input logic [1:0] c, input logic [11:0] pn);
    for (int k = 0; k < 8; k++) begin
      cycle  = 3'(k);
      pc_inc = inc;
      cmd    = c;
      pc_new = pn;
      tick();
    end
    pc_inc = 1'b0;
    cmd    = C_NOP;
  endtask

  initial begin
    total = 0; bad = 0; ovf_seen3 = 0; ovf_seen7 = 0;
    rst_n = 1'b0; cycle = '0; pc_inc = 1'b0; cmd = C_NOP; pc_new = '0;
    model_reset();
    tick();
    chk("rst.pc3", 32'(pc3), 32'h0);
    chk("rst.pc7", 32'(pc7), 32'h0);
    rst_n = 1'b1;

    // Five increment frames
    repeat (5) frame(1'b1, C_NOP, 12'h000);
    chk("inc5.pc3",  32'(pc3),  32'h005);
    chk("inc5.sp3",  32'(sp3),  32'h0);
    chk("inc5.cnt3", 32'(cnt3), 32'h0);

    // JUMP on a non-exec phase is ignored
    cycle = 3'd3; cmd = C_JUMP; pc_new = 12'hABC;
    tick();
    cmd = C_NOP;
    chk("jmp_c3.pc3", 32'(pc3), 32'h005);

    // Wrap 0xFFF -> 0x000 with no flag
    frame(1'b0, C_JUMP, 12'hFFF);
    chk("jmp.pc3", 32'(pc3), 32'hFFF);
    frame(1'b1, C_NOP, 12'h000);
    chk("wrap.pc3",  32'(pc3),  32'h000);
    chk("wrap.ovf3", 32'(ovf3), 32'h0);

    // Simple CALL / RET
    frame(1'b0, C_JUMP, 12'h010);
    frame(1'b0, C_CALL, 12'h200);
    chk("call.pc3",  32'(pc3),  32'h200);
    chk("call.cnt3", 32'(cnt3), 32'h1);
    frame(1'b0, C_RET, 12'h000);
    chk("ret.pc3",  32'(pc3),  32'h010);
    chk("ret.cnt3", 32'(cnt3), 32'h0);

    // Four CALLs from 0x001..0x004: depth 3 overflows once
    frame(1'b0, C_JUMP, 12'h001);
    ovf_seen3 = 0; ovf_seen7 = 0;
    for (int k = 2; k <= 5; k++) frame(1'b0, C_CALL, 12'(k));
    chk("call4.ovf_count3", 32'(ovf_seen3), 32'd1);
    chk("call4.ovf_count7", 32'(ovf_seen7), 32'd0);
    frame(1'b0, C_RET, 12'h000);
    chk("ret1.pc3", 32'(pc3), 32'h004);
    frame(1'b0, C_RET, 12'h000);
    chk("ret2.pc3", 32'(pc3), 32'h003);
    frame(1'b0, C_RET, 12'h000);
    chk("ret3.pc3", 32'(pc3), 32'h002);
    frame(1'b0, C_RET, 12'h000);
    chk("ret4.pc3",  32'(pc3),  32'h004);
    chk("ret4.unf3", 32'(unf3), 32'h1);
    chk("ret4.pc7",  32'(pc7),  32'h001);
    chk("ret4.unf7", 32'(unf7), 32'h0);

    // Seven CALLs / seven RETs after a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    frame(1'b0, C_JUMP, 12'h001);
    ovf_seen3 = 0; ovf_seen7 = 0;
    for (int k = 2; k <= 8; k++) frame(1'b0, C_CALL, 12'(k));
    chk("call7.ovf_count7", 32'(ovf_seen7), 32'd0);
    chk("call7.cnt7",       32'(cnt7),      32'd7);
    for (int k = 1; k <= 7; k++) begin
      frame(1'b0, C_RET, 12'h000);
      chk("ret7.pc7", 32'(pc7), 32'(8 - k));
    end

    // Async reset in the middle of a CALL at cycle 7
    for (int k = 0; k < 7; k++) begin
      cycle = 3'(k); cmd = C_CALL; pc_new = 12'h3AB;
      tick();
    end
    cycle = 3'd7; cmd = C_CALL; pc_new = 12'h3AB;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.pc3",  32'(pc3),  32'h0);
    chk("arst.sp3",  32'(sp3),  32'h0);
    chk("arst.cnt3", 32'(cnt3), 32'h0);
    chk("arst.pc7",  32'(pc7),  32'h0);
    chk("arst.cnt7", 32'(cnt7), 32'h0);
    tick();
    #2;
    rst_n = 1'b1;
    cmd = C_NOP;
    frame(1'b0, C_RET, 12'h000);
    chk("arst_ret.pc3",  32'(pc3),  32'h0);
    chk("arst_ret.unf3", 32'(unf3), 32'h1);
    chk("arst_ret.pc7",  32'(pc7),  32'h0);
    chk("arst_ret.unf7", 32'(unf7), 32'h1);
    frame(1'b0, C_NOP, 12'h000);
    chk("unf_pulse.unf3", 32'(unf3), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
